stopwatch_core: RTL and testbench

- Parametrised successor to the stopwatch select/adjust logic. Holds the minutes:seconds count and advances it on a 1 Hz tick.
- Supports per-field adjust (up or down) on an adjust-rate tick, plus pause toggle, clear and full-count wrap signalling.
- Single clock domain: all timing arrives as one-cycle enable ticks from the clock-divider block, not as derived clocks.
- Outputs feed the display/BCD conversion path.

---
 rtl/stopwatch_core_if.sv | 40 ++++
 rtl/stopwatch_core.sv | 134 +++++++++++++
 tb/tb_stopwatch_core.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_core_if.sv
// ---------------------------------------------------------------------------
// stopwatch_core_if
// Bundles the control/tick inputs and the count outputs of stopwatch_core.
//   master : tick/control driver (clock divider, buttons), reads count outputs
//   slave  : the stopwatch core itself
// Signals:
//   tick_1hz, tick_adj   one-cycle enable pulses
//   adj, sel, adj_down   adjust-mode levels
//   pause_tgl, clear     one-cycle command pulses
//   seconds, minutes     current count (registered)
//   running, adjusting   run state and registered copy of adj
//   wrap                 one-cycle full-wrap pulse
// ---------------------------------------------------------------------------
interface stopwatch_core_if #(
  parameter int SEC_W = 6,
  parameter int MIN_W = 7
);
  logic             tick_1hz;
  logic             tick_adj;
  logic             adj;
  logic             sel;
  logic             adj_down;
  logic             pause_tgl;
  logic             clear;
  logic [SEC_W-1:0] seconds;
  logic [MIN_W-1:0] minutes;
  logic             running;
  logic             adjusting;
  logic             wrap;

  modport master (
    output tick_1hz, tick_adj, adj, sel, adj_down, pause_tgl, clear,
    input  seconds, minutes, running, adjusting, wrap
  );

  modport slave (
    input  tick_1hz, tick_adj, adj, sel, adj_down, pause_tgl, clear,
    output seconds, minutes, running, adjusting, wrap
  );
endinterface

// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
// Minutes:seconds counter advanced by a 1 Hz enable tick, with per-field
// up/down adjust on an adjust-rate tick, pause toggle, clear and a one-cycle
// full-wrap pulse. All outputs are registered.
// Ports:
//   clk   system clock
//   rst   synchronous reset, active low
//   bus   stopwatch_core_if.slave (ticks/controls in, count/status out)
// ---------------------------------------------------------------------------
module stopwatch_core #(
  parameter int SEC_W   = 6,
  parameter int MIN_W   = 7,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 99
) (
  input  logic clk,
  input  logic rst,
  stopwatch_core_if.slave bus
);

  localparam logic [SEC_W-1:0] L_SEC_MAX = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] L_MIN_MAX = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0] L_SEC_ONE = SEC_W'(1);
  localparam logic [MIN_W-1:0] L_MIN_ONE = MIN_W'(1);

  // Operating mode is a pure decode of adj/sel/running; the only state the
  // mode depends on is the running register.
  typedef enum logic [1:0] {
    MODE_COUNT,
    MODE_HOLD,
    MODE_ADJ_SEC,
    MODE_ADJ_MIN
  } mode_t;

  logic [SEC_W-1:0] r_seconds;
  logic [MIN_W-1:0] r_minutes;
  logic             r_running;
  logic             r_adjusting;
  logic             r_wrap;

  mode_t            w_mode;
  logic [SEC_W-1:0] w_seconds_next;
  logic [MIN_W-1:0] w_minutes_next;
  logic             w_running_next;
  logic             w_wrap_next;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seconds   <= '0;
      r_minutes   <= '0;
      r_running   <= 1'b1;
      r_adjusting <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_seconds   <= w_seconds_next;
      r_minutes   <= w_minutes_next;
      r_running   <= w_running_next;
      r_adjusting <= bus.adj;
      r_wrap      <= w_wrap_next;
    end
  end

  // Mode decode
  always_comb begin
    w_mode = MODE_HOLD;
    if (bus.adj) begin
      w_mode = bus.sel ? MODE_ADJ_SEC : MODE_ADJ_MIN;
    end else if (r_running) begin
      w_mode = MODE_COUNT;
    end
  end

  // Next-state logic
  always_comb begin
    w_seconds_next = r_seconds;
    w_minutes_next = r_minutes;
    w_wrap_next    = 1'b0;
    // Pause toggles regardless of mode or clear; a new state set during
    // adjust only becomes visible once adj drops.
    w_running_next = r_running ^ bus.pause_tgl;

    if (bus.clear) begin
      w_seconds_next = '0;
      w_minutes_next = '0;
    end else begin
      unique case (w_mode)
        MODE_COUNT: begin
          if (bus.tick_1hz) begin
            if (r_seconds != L_SEC_MAX) begin
              w_seconds_next = r_seconds + L_SEC_ONE;
            end else begin
              w_seconds_next = '0;
              if (r_minutes != L_MIN_MAX) begin
                w_minutes_next = r_minutes + L_MIN_ONE;
              end else begin
                w_minutes_next = '0;
                w_wrap_next    = 1'b1;
              end
            end
          end
        end
        MODE_ADJ_SEC: begin
          // Field wraps within itself; no carry into minutes.
          if (bus.tick_adj) begin
            if (bus.adj_down) begin
              w_seconds_next = (r_seconds == '0) ? L_SEC_MAX : r_seconds - L_SEC_ONE;
            end else begin
              w_seconds_next = (r_seconds == L_SEC_MAX) ? '0 : r_seconds + L_SEC_ONE;
            end
          end
        end
        MODE_ADJ_MIN: begin
          if (bus.tick_adj) begin
            if (bus.adj_down) begin
              w_minutes_next = (r_minutes == '0) ? L_MIN_MAX : r_minutes - L_MIN_ONE;
            end else begin
              w_minutes_next = (r_minutes == L_MIN_MAX) ? '0 : r_minutes + L_MIN_ONE;
            end
          end
        end
        default: ; // MODE_HOLD: frozen
      endcase
    end
  end

  assign bus.seconds   = r_seconds;
  assign bus.minutes   = r_minutes;
  assign bus.running   = r_running;
  assign bus.adjusting = r_adjusting;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_core
// Drives two stopwatch_core instances (MIN_MAX=99/MIN_W=7 and MIN_MAX=59/
// MIN_W=6) with identical stimulus: a directed sequence for the boundary
// cases followed by randomized cycles. A total-seconds reference model checks
// every output of both instances after every clock.
// ---------------------------------------------------------------------------
module tb_stopwatch_core;

  localparam int SMAX = 59;

  logic clk = 1'b0;
  logic rst;
  logic tick_1hz, tick_adj, adj, sel, adj_down, pause_tgl, clear;

  always #5 clk = ~clk;

  stopwatch_core_if #(.SEC_W(6), .MIN_W(7)) if_a ();
  stopwatch_core_if #(.SEC_W(6), .MIN_W(6)) if_b ();

  assign if_a.tick_1hz  = tick_1hz;
  assign if_a.tick_adj  = tick_adj;
  assign if_a.adj       = adj;
  assign if_a.sel       = sel;
  assign if_a.adj_down  = adj_down;
  assign if_a.pause_tgl = pause_tgl;
  assign if_a.clear     = clear;
  assign if_b.tick_1hz  = tick_1hz;
  assign if_b.tick_adj  = tick_adj;
  assign if_b.adj       = adj;
  assign if_b.sel       = sel;
  assign if_b.adj_down  = adj_down;
  assign if_b.pause_tgl = pause_tgl;
  assign if_b.clear     = clear;

  stopwatch_core #(.SEC_W(6), .MIN_W(7), .SEC_MAX(59), .MIN_MAX(99)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  stopwatch_core #(.SEC_W(6), .MIN_W(6), .SEC_MAX(59), .MIN_MAX(59)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int m_sec[2], m_min[2], m_run[2], m_adj[2], m_wrap[2];
  int m_mmax[2] = '{99, 59};

  int n_checks = 0;
  int n_fails  = 0;
  int n_cycle  = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n_cycle, obs, exp);
    end
  endtask

  // Count is treated as total elapsed seconds modulo the full period;
  // adjust is per-field modular add of +1 or -1.
  task automatic model_step(input int k);
    int total, period;
    if (!rst) begin
      m_sec[k] = 0; m_min[k] = 0; m_run[k] = 1; m_adj[k] = 0; m_wrap[k] = 0;
      return;
    end
    m_wrap[k] = 0;
    if (clear) begin
      m_sec[k] = 0; m_min[k] = 0;
    end else if (adj) begin
      if (tick_adj) begin
        if (sel) m_sec[k] = (m_sec[k] + (adj_down ? SMAX : 1)) % (SMAX + 1);
        else     m_min[k] = (m_min[k] + (adj_down ? m_mmax[k] : 1)) % (m_mmax[k] + 1);
      end
    end else if (m_run[k] != 0 && tick_1hz) begin
      period = (m_mmax[k] + 1) * (SMAX + 1);
      total  = m_min[k] * (SMAX + 1) + m_sec[k] + 1;
      if (total == period) begin
        total = 0;
        m_wrap[k] = 1;
      end
      m_sec[k] = total % (SMAX + 1);
      m_min[k] = total / (SMAX + 1);
    end
    if (pause_tgl) m_run[k] = 1 - m_run[k];
    m_adj[k] = adj ? 1 : 0;
  endtask

  task automatic cycle(input logic i_rst, i_t1, i_ta, i_adj, i_sel, i_dn, i_pt, i_clr);
    rst = i_rst; tick_1hz = i_t1; tick_adj = i_ta; adj = i_adj;
    sel = i_sel; adj_down = i_dn; pause_tgl = i_pt; clear = i_clr;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    n_cycle++;
    check_eq("a_seconds",   int'(if_a.seconds),   m_sec[0]);
    check_eq("a_minutes",   int'(if_a.minutes),   m_min[0]);
    check_eq("a_running",   int'(if_a.running),   m_run[0]);
    check_eq("a_adjusting", int'(if_a.adjusting), m_adj[0]);
    check_eq("a_wrap",      int'(if_a.wrap),      m_wrap[0]);
    check_eq("b_seconds",   int'(if_b.seconds),   m_sec[1]);
    check_eq("b_minutes",   int'(if_b.minutes),   m_min[1]);
    check_eq("b_running",   int'(if_b.running),   m_run[1]);
    check_eq("b_adjusting", int'(if_b.adjusting), m_adj[1]);
    check_eq("b_wrap",      int'(if_b.wrap),      m_wrap[1]);
  endtask

  logic r_adj_lvl;

  initial begin
    // Argument order: rst, tick_1hz, tick_adj, adj, sel, adj_down, pause_tgl, clear
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_running", int'(if_a.running), 1);
    check_eq("rst_seconds", int'(if_a.seconds), 0);
    repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check_eq("three_ticks", int'(if_a.seconds), 3);

    // Preload 98:59 (dut_b: 58:59) via downward adjust from 00:00
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 1, 1, 0, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 1, 1, 0, 0);   // tick_1hz alongside tick_adj: one step only
    check_eq("adj_sec_down_from0", int'(if_a.seconds), 59);
    check_eq("adj_sec_min_kept",   int'(if_a.minutes), 98);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check_eq("carry_minutes", int'(if_a.minutes), 99);
    check_eq("carry_no_wrap", int'(if_a.wrap), 0);

    // 99:59 -> 00:00 with wrap
    cycle(1, 0, 1, 1, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check_eq("full_wrap_pulse", int'(if_a.wrap), 1);
    check_eq("full_wrap_min",   int'(if_a.minutes), 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("wrap_one_cycle", int'(if_a.wrap), 0);

    // Pause / resume
    cycle(1, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check_eq("paused_running", int'(if_a.running), 0);
    check_eq("paused_seconds", int'(if_a.seconds), 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check_eq("resumed_seconds", int'(if_a.seconds), 1);

    // Minutes up past max: 0 -> max (down) -> 0 (up)
    cycle(1, 0, 1, 1, 0, 1, 0, 0);
    check_eq("b_min_at_max", int'(if_b.minutes), 59);
    cycle(1, 0, 1, 1, 0, 0, 0, 0);
    check_eq("min_up_wrap",   int'(if_a.minutes), 0);
    check_eq("min_up_sec_kept", int'(if_a.seconds), 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);

    // Priority
    repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 1);
    check_eq("clear_beats_tick", int'(if_a.seconds), 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 1, 0, 0, 0, 1, 1);
    check_eq("rst_beats_pause", int'(if_a.running), 1);

    // Randomized phase
    r_adj_lvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) r_adj_lvl = ~r_adj_lvl;
      cycle(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 2) == 0),
            r_adj_lvl,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
